vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, the successor of the fixed 640x480 counter. It derives a pixel-rate tick from the system clock using an integer divider, and scans programmable horizontal and vertical timings. It drives hsync, vsync, video_on and the pixel coordinates, and all of these are coherent in the same cycle. It also adds line/frame strobes, a frame counter, sync polarity control and a run enable. It sits between the clock/reset and the game pixel renderer.

Parameters:
CLK_DIV, 4, system clocks per pixel; must be >= 1 (4 gives 25 MHz from 100 MHz)
H_DISP, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISP, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
FRAME_W, 8, frame counter width
Derived: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL likewise; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

Ports:
clk_100MHz  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run control; low freezes timing
p_tick  out  1  one-clk pixel strobe, once per CLK_DIV clocks
x  out  XW  horizontal position, 0..H_TOTAL-1
y  out  YW  vertical position, 0..V_TOTAL-1
video_on  out  1  x < H_DISP and y < V_DISP
hsync  out  1  horizontal sync, polarity H_POL
vsync  out  1  vertical sync, polarity V_POL
line_start  out  1  one-clk strobe when x wraps to 0
frame_start  out  1  one-clk strobe when (x,y) wraps to (0,0)
frame_count  out  FRAME_W  frames started since reset, wraps modulo 2^FRAME_W

Behaviour:
- The clock is clk_100MHz. Reset is asynchronous and active-low: reset_n.
- Reset values: divider = 0; x = H_TOTAL-1; y = V_TOTAL-1; video_on = 0; hsync = ~H_POL; vsync = ~V_POL; p_tick = 0; line_start = 0; frame_start = 0; frame_count = 0.
- Divider: counts 0..CLK_DIV-1 while enable = 1. p_tick is high for exactly the one clk in which the divider equals CLK_DIV-1. If CLK_DIV = 1, p_tick = enable.
- Tick handling: on a clk edge with p_tick = 1, x advances. When x = H_TOTAL-1, x wraps to 0 and y advances. When y is also V_TOTAL-1, y wraps to 0.
- Output registers: x, y, video_on, hsync, vsync, line_start and frame_start are all registered from the next-state counter values. They therefore describe the same pixel in the same cycle, with zero skew between them.
- Sync windows:
  - hsync is active for H_DISP+H_FP <= x <= H_DISP+H_FP+H_SYNC-1 (656..751 by default).
  - vsync is active for V_DISP+V_FP <= y <= V_DISP+V_FP+V_SYNC-1 (490..491 by default).
- Strobes:
  - line_start = 1 for the one clk after a tick that loads x = 0; otherwise 0.
  - frame_start = 1 for the one clk after a tick that loads (0,0); it coincides with a line_start.
  - frame_count increments on the same edge that raises frame_start.
- First tick after reset: it loads (0,0), so line_start = frame_start = 1 and frame_count = 1.
- enable = 0:
  - divider, counters and all outputs hold their values; p_tick = 0.
  - strobes clear after one clk and are never repeated.
  - When enable returns to 1, the divider resumes from its held value.
- reset_n asserted mid-frame: all state returns to the reset values immediately (asynchronously). No partial strobe is emitted.
- Width rules: comparisons use XW/YW-bit unsigned arithmetic; there is no overflow, because the counters never exceed H_TOTAL-1 and V_TOTAL-1.
- Elaboration checks: CLK_DIV >= 1 and all porch/sync/display parameters >= 1. A violation raises an $error during elaboration.

Decomposition:
- Package vga_timing_pkg:
  - the default 640x480@60 constants;
  - H_TOTAL/V_TOTAL helper functions;
  - polarity constants SYNC_ACTIVE_LOW and SYNC_ACTIVE_HIGH.
- Sub-module pixel_tick_gen: the CLK_DIV divider with enable, producing p_tick. It is reusable by the sprite and audio blocks.

Test Plan:
- Defaults, release reset, enable = 1 -> p_tick every 4 clks; first tick gives x = 0, y = 0, frame_start = 1, frame_count = 1, video_on = 1.
- Run one line -> hsync low for exactly x = 656..751 (96 ticks); line_start once per 800 ticks; video_on low for x = 640..799.
- Run one frame -> vsync low for y = 490..491 only; frame_start every 420000 ticks (1680000 clks); x/y/video_on never skewed.
- Drop enable for 37 clks mid-line at x = 300 -> x holds at 300, no p_tick; resume and the tick spacing continues correctly.
- Assert reset_n = 0 at x = 700, y = 491 -> outputs immediately show x = 799, y = 524, both syncs inactive, frame_count = 0.
- CLK_DIV = 1, H_POL = V_POL = 1, small timing (H 8/2/2/2, V 4/1/1/1), FRAME_W = 2 -> active-high syncs at x = 10..11, y = 5; frame_count wraps 3 -> 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers: 640x480@60 defaults, line/frame totals, sync polarity levels.
package vga_timing_pkg;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_H_DISP  = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_DISP  = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BP    = 33;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int h_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

    function automatic int v_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// Integer clock divider producing a one-clock strobe every CLK_DIV enabled clocks; holds while disabled.
module pixel_tick_gen #(
    parameter int  CLK_DIV = 4,
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic p_tick
);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_param_check
        $error("pixel_tick_gen: CLK_DIV must be >= 1");
    end

    logic [DW-1:0] div;

    // Gated by reset_n so a CLK_DIV = 1 instance stays quiet while held in reset.
    assign p_tick = reset_n & enable & (div == DIV_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
        end else if (enable) begin
            div <= (div == DIV_MAX) ? '0 : div + 1'b1;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster generator: pixel-rate tick, x/y scan, registered syncs, video_on and strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int  CLK_DIV = DEF_CLK_DIV,
    parameter int  H_DISP  = DEF_H_DISP,
    parameter int  H_FP    = DEF_H_FP,
    parameter int  H_SYNC  = DEF_H_SYNC,
    parameter int  H_BP    = DEF_H_BP,
    parameter int  V_DISP  = DEF_V_DISP,
    parameter int  V_FP    = DEF_V_FP,
    parameter int  V_SYNC  = DEF_V_SYNC,
    parameter int  V_BP    = DEF_V_BP,
    parameter bit  H_POL   = SYNC_ACTIVE_LOW,
    parameter bit  V_POL   = SYNC_ACTIVE_LOW,
    parameter int  FRAME_W = 8,
    localparam int H_TOTAL = h_total(H_DISP, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = v_total(V_DISP, V_FP, V_SYNC, V_BP),
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic               clk_100MHz,
    input  logic               reset_n,
    input  logic               enable,
    output logic               p_tick,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);
    localparam logic [XW-1:0] X_MAX    = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_DISP   = XW'(H_DISP);
    localparam logic [YW-1:0] Y_DISP   = YW'(V_DISP);
    localparam logic [XW-1:0] HS_START = XW'(H_DISP + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] VS_START = YW'(V_DISP + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_DISP + V_FP + V_SYNC - 1);

    if (CLK_DIV < 1 || H_DISP < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_DISP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FRAME_W < 1) begin : g_param_check
        $error("vga_timing_gen: all timing parameters must be >= 1");
    end

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk_100MHz),
        .reset_n (reset_n),
        .enable  (enable),
        .p_tick  (p_tick)
    );

    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic          wrap_x;
    logic          wrap_xy;
    logic          hs_active;
    logic          vs_active;

    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == X_MAX) begin
                x_next = '0;
                y_next = (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x_next = x + 1'b1;
            end
        end
    end

    // Everything below is decoded from the next-state position so all outputs describe one pixel.
    assign wrap_x    = p_tick && (x_next == '0);
    assign wrap_xy   = wrap_x && (y_next == '0);
    assign hs_active = (x_next >= HS_START) && (x_next <= HS_END);
    assign vs_active = (y_next >= VS_START) && (y_next <= VS_END);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            x           <= X_MAX;
            y           <= Y_MAX;
            video_on    <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            x           <= x_next;
            y           <= y_next;
            video_on    <= (x_next < X_DISP) && (y_next < Y_DISP);
            hsync       <= hs_active ? H_POL : ~H_POL;
            vsync       <= vs_active ? V_POL : ~V_POL;
            line_start  <= wrap_x;
            frame_start <= wrap_xy;
            if (wrap_xy) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny fast-divider instance checked against an arithmetic model.
module tb_vga_timing_gen;
    logic clk_100MHz = 1'b0;
    logic reset_n    = 1'b0;
    logic enable     = 1'b1;

    always #5 clk_100MHz = ~clk_100MHz;

    logic       pta, voa, hsa, vsa, lsa, fsa;
    logic [9:0] xa, ya;
    logic [7:0] fca;
    logic       ptb, vob, hsb, vsb, lsb, fsb;
    logic [3:0] xb;
    logic [2:0] yb;
    logic [1:0] fcb;

    vga_timing_gen dut_a (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .p_tick(pta),
        .x(xa), .y(ya), .video_on(voa), .hsync(hsa), .vsync(vsa),
        .line_start(lsa), .frame_start(fsa), .frame_count(fca)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .FRAME_W(2)
    ) dut_b (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .p_tick(ptb),
        .x(xb), .y(yb), .video_on(vob), .hsync(hsb), .vsync(vsb),
        .line_start(lsb), .frame_start(fsb), .frame_count(fcb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count enabled clocks since reset; tick k happens on every CLK_DIV-th one,
    // and tick k (k >= 1) shows raster position k-1 taken modulo the frame size.
    longint na = 0, nb = 0;
    bit     lta = 1'b0, ltb = 1'b0;

    always @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            na = 0; nb = 0; lta = 1'b0; ltb = 1'b0;
        end else if (enable) begin
            na++; nb++;
            lta = (na % 4 == 0);
            ltb = 1'b1;
        end else begin
            lta = 1'b0; ltb = 1'b0;
        end
    end

    task automatic check_dut(input string tag, input int cd, input int ht, input int vt,
                             input int hd, input int vd, input int hs0, input int hs1,
                             input int vs0, input int vs1, input bit hp, input bit vp,
                             input int fw, input longint n, input bit lt,
                             input logic [63:0] ax, input logic [63:0] ay, input logic [63:0] afc,
                             input logic avo, input logic ahs, input logic avs,
                             input logic als, input logic afs, input logic apt);
        longint t, p, ex, ey, efc;
        bit ehs, evs, evo, ept;
        t = n / cd;
        if (t == 0) begin
            ex = ht - 1; ey = vt - 1; efc = 0;
        end else begin
            p   = (t - 1) % (ht * vt);
            ex  = p % ht;
            ey  = p / ht;
            efc = ((t - 1) / (ht * vt) + 1) % (longint'(1) << fw);
        end
        evo = (ex < hd) && (ey < vd);
        ehs = (ex >= hs0 && ex <= hs1) ? hp : !hp;
        evs = (ey >= vs0 && ey <= vs1) ? vp : !vp;
        ept = reset_n && enable && (n % cd == cd - 1);
        chk({tag, ".x"}, ax, ex);
        chk({tag, ".y"}, ay, ey);
        chk({tag, ".frame_count"}, afc, efc);
        chk({tag, ".video_on"}, avo, evo);
        chk({tag, ".hsync"}, ahs, ehs);
        chk({tag, ".vsync"}, avs, evs);
        chk({tag, ".line_start"}, als, lt && ex == 0);
        chk({tag, ".frame_start"}, afs, lt && ex == 0 && ey == 0);
        chk({tag, ".p_tick"}, apt, ept);
    endtask

    always @(negedge clk_100MHz) begin
        #1;
        check_dut("a", 4, 800, 525, 640, 480, 656, 751, 490, 491, 1'b0, 1'b0, 8, na, lta,
                  xa, ya, fca, voa, hsa, vsa, lsa, fsa, pta);
        check_dut("b", 1, 14, 7, 8, 4, 10, 11, 5, 5, 1'b1, 1'b1, 2, nb, ltb,
                  xb, yb, fcb, vob, hsb, vsb, lsb, fsb, ptb);
    end

    typedef struct {
        int n;
        int x; int y;
        bit hs; bit vs; bit vo; bit ls; bit fs;
        int fc;
    } vec_t;

    vec_t tbl[9];
    int   cur;
    int   hs_low, vo_low, ls_cnt, rst_at;

    initial begin
        // Hand-derived expectations for the 14x7 raster, CLK_DIV = 1, active-high syncs.
        tbl[0] = '{n:1,   x:0,  y:0, hs:0, vs:0, vo:1, ls:1, fs:1, fc:1};
        tbl[1] = '{n:11,  x:10, y:0, hs:1, vs:0, vo:0, ls:0, fs:0, fc:1};
        tbl[2] = '{n:12,  x:11, y:0, hs:1, vs:0, vo:0, ls:0, fs:0, fc:1};
        tbl[3] = '{n:13,  x:12, y:0, hs:0, vs:0, vo:0, ls:0, fs:0, fc:1};
        tbl[4] = '{n:15,  x:0,  y:1, hs:0, vs:0, vo:1, ls:1, fs:0, fc:1};
        tbl[5] = '{n:50,  x:7,  y:3, hs:0, vs:0, vo:1, ls:0, fs:0, fc:1};
        tbl[6] = '{n:81,  x:10, y:5, hs:1, vs:1, vo:0, ls:0, fs:0, fc:1};
        tbl[7] = '{n:99,  x:0,  y:0, hs:0, vs:0, vo:1, ls:1, fs:1, fc:2};
        tbl[8] = '{n:295, x:0,  y:0, hs:0, vs:0, vo:1, ls:1, fs:1, fc:0};

        @(negedge clk_100MHz); #1;
        chk("rst.xa", xa, 799);
        chk("rst.ya", ya, 524);
        chk("rst.hsa", hsa, 1);
        chk("rst.pta", pta, 0);
        chk("rst.ptb", ptb, 0);
        chk("rst.hsb", hsb, 0);

        @(negedge clk_100MHz);
        reset_n = 1'b1;
        cur = 0;
        for (int i = 0; i < 9; i++) begin
            repeat (tbl[i].n - cur) @(negedge clk_100MHz);
            cur = tbl[i].n;
            #1;
            chk($sformatf("tbl%0d.x", i), xb, tbl[i].x);
            chk($sformatf("tbl%0d.y", i), yb, tbl[i].y);
            chk($sformatf("tbl%0d.hsync", i), hsb, tbl[i].hs);
            chk($sformatf("tbl%0d.vsync", i), vsb, tbl[i].vs);
            chk($sformatf("tbl%0d.video_on", i), vob, tbl[i].vo);
            chk($sformatf("tbl%0d.line_start", i), lsb, tbl[i].ls);
            chk($sformatf("tbl%0d.frame_start", i), fsb, tbl[i].fs);
            chk($sformatf("tbl%0d.frame_count", i), fcb, tbl[i].fc);
        end

        // Fresh start of the default raster: first tick on the 4th clock loads (0,0).
        @(negedge clk_100MHz);
        reset_n = 1'b0;
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        #1;
        chk("pre_tick.x", xa, 799);
        chk("pre_tick.p_tick", pta, 1);
        @(negedge clk_100MHz); #1;
        chk("first_tick.x", xa, 0);
        chk("first_tick.y", ya, 0);
        chk("first_tick.frame_start", fsa, 1);
        chk("first_tick.frame_count", fca, 1);
        chk("first_tick.video_on", voa, 1);

        // One whole line, sampled once per pixel: x = 1..799 then the wrap to 0.
        hs_low = 0; vo_low = 0; ls_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            repeat (4) @(negedge clk_100MHz);
            #1;
            if (!hsa) hs_low++;
            if (!voa) vo_low++;
            if (lsa)  ls_cnt++;
        end
        chk("line.hsync_low_pixels", hs_low, 96);
        chk("line.video_off_pixels", vo_low, 160);
        chk("line.line_start_count", ls_cnt, 1);

        // Reach x = 300 on line 1 with the divider at 2, then freeze for 37 clocks.
        repeat (1202) @(negedge clk_100MHz);
        enable = 1'b0;
        #1;
        chk("freeze.entry_x", xa, 300);
        for (int i = 0; i < 37; i++) begin
            @(negedge clk_100MHz);
            if (i == 36) enable = 1'b1;
            #1;
            chk("freeze.x", xa, 300);
            chk("freeze.p_tick", pta, 0);
        end
        @(negedge clk_100MHz); #1;
        chk("resume.x_before_tick", xa, 300);
        chk("resume.p_tick", pta, 1);
        @(negedge clk_100MHz); #1;
        chk("resume.x_after_tick", xa, 301);

        // Advance to x = 700, then reset asynchronously between clock edges.
        repeat (1596) @(negedge clk_100MHz);
        #1;
        chk("pre_reset.x", xa, 700);
        chk("pre_reset.hsb", hsb, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst.xa", xa, 799);
        chk("async_rst.ya", ya, 524);
        chk("async_rst.hsa", hsa, 1);
        chk("async_rst.vsa", vsa, 1);
        chk("async_rst.fca", fca, 0);
        chk("async_rst.voa", voa, 0);
        chk("async_rst.lsa", lsa, 0);
        chk("async_rst.xb", xb, 13);
        chk("async_rst.yb", yb, 6);
        chk("async_rst.hsb", hsb, 0);
        chk("async_rst.vsb", vsb, 0);
        chk("async_rst.fcb", fcb, 0);

        // Random run/freeze pattern with one more mid-cycle reset pulse.
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        rst_at = int'($urandom_range(1500, 2500));
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_100MHz);
            reset_n = 1'b1;
            enable  = ($urandom_range(0, 9) != 0);
            if (i == rst_at) #3 reset_n = 1'b0;
        end
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        @(negedge clk_100MHz); #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
